// File: rtl/vend_pkg.sv
// vend_pkg: shared types and constants for the vending controller.
//   state_e   - controller states (IDLE, COLLECT, DISPENSE, CHANGE)
//   NICKEL_C  - value of a nickel in cents
//   DIME_C    - value of a dime in cents
//   ITEM_*    - item selection codes
//   price_of  - maps an item code to its price (0 for ITEM_NONE)
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_e;

  localparam logic [7:0] NICKEL_C = 8'd5;
  localparam logic [7:0] DIME_C   = 8'd10;

  localparam logic [1:0] ITEM_NONE = 2'd0;
  localparam logic [1:0] ITEM_1    = 2'd1;
  localparam logic [1:0] ITEM_2    = 2'd2;
  localparam logic [1:0] ITEM_3    = 2'd3;

  function automatic logic [7:0] price_of(input logic [1:0] item,
                                          input logic [7:0] p1,
                                          input logic [7:0] p2,
                                          input logic [7:0] p3);
    case (item)
      ITEM_1:  return p1;
      ITEM_2:  return p2;
      ITEM_3:  return p3;
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_controller_change_sequencer.sv
// change_sequencer: paces a refund as one-cycle nickel pulses.
//   clock, reset  - system clock, synchronous active-high reset
//   load_i        - one-cycle request to start paying out credit_i
//   credit_i      - amount to refund in cents (multiple of 5)
//   nickel_out_o  - registered pulse, one nickel returned this cycle
//   done_o        - high during the final nickel pulse of a refund
// The first pulse appears in the cycle right after load_i, then every
// second cycle, so N nickels occupy 2N-1 cycles.
module change_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load_i,
  input  logic [CREDIT_W-1:0] credit_i,
  output logic                nickel_out_o,
  output logic                done_o
);

  localparam logic [CREDIT_W-1:0] STEP = CREDIT_W'(NICKEL_C);

  logic [CREDIT_W-1:0] rem_q, rem_d;
  logic                active_q, active_d;
  logic                nickel_q, nickel_d;

  always_comb begin
    rem_d    = rem_q;
    active_d = active_q;
    nickel_d = 1'b0;
    if (load_i) begin
      rem_d    = credit_i;
      active_d = (credit_i != '0);
      nickel_d = (credit_i != '0);
    end else if (active_q) begin
      if (nickel_q) begin
        rem_d = rem_q - STEP;
        // The pulse that pays the last nickel ends the refund.
        if (rem_q == STEP) begin
          active_d = 1'b0;
        end
      end else begin
        nickel_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q    <= '0;
      active_q <= 1'b0;
      nickel_q <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      active_q <= active_d;
      nickel_q <= nickel_d;
    end
  end

  assign nickel_out_o = nickel_q;
  assign done_o       = active_q && nickel_q && (rem_q == STEP);

endmodule

// File: rtl/vend_controller.sv
// vend_controller: coin credit, item selection, dispense handshake and
// change return for a three-item vending machine.
//   clock, reset    - system clock, synchronous active-high reset
//   nickel_in       - one-cycle pulse, 5 cents inserted
//   dime_in         - one-cycle pulse, 10 cents inserted
//   item_sel        - item code (0 none, 1..3)
//   select_valid    - one-cycle purchase request for item_sel
//   cancel          - one-cycle request to refund all credit
//   dispense_ready  - mechanism accepted the dispense
//   dispense        - held high until dispense_ready is sampled
//   dispense_item   - latched item code, valid while dispense=1
//   nickel_out      - one-cycle pulse, one nickel returned
//   coin_reject     - one-cycle pulse, this cycle's coins returned
//   sel_short       - one-cycle pulse, selection refused (low credit)
//   credit          - current credit in cents
//   busy            - high while dispensing or returning change
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned PRICE_1    = 15,
  parameter int unsigned PRICE_2    = 20,
  parameter int unsigned PRICE_3    = 25,
  parameter int unsigned MAX_CREDIT = 35,
  parameter int unsigned CREDIT_W   = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                nickel_in,
  input  logic                dime_in,
  input  logic [1:0]          item_sel,
  input  logic                select_valid,
  input  logic                cancel,
  input  logic                dispense_ready,
  output logic                dispense,
  output logic [1:0]          dispense_item,
  output logic                nickel_out,
  output logic                coin_reject,
  output logic                sel_short,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam logic [7:0] MAX_C = 8'(MAX_CREDIT);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                disp_q, disp_d;
  logic [1:0]          item_q, item_d;
  logic                reject_q, reject_d;
  logic                short_q, short_d;
  logic                busy_q, busy_d;

  logic [7:0]          coin_val;
  logic [7:0]          coin_sum;
  logic [7:0]          sel_price;
  logic [7:0]          item_price;
  logic [CREDIT_W-1:0] remainder;
  logic                take_coins;
  logic                load;
  logic [CREDIT_W-1:0] load_val;
  logic                seq_nickel;
  logic                seq_done;

  assign coin_val   = (nickel_in ? NICKEL_C : 8'd0) + (dime_in ? DIME_C : 8'd0);
  assign coin_sum   = 8'(credit_q) + coin_val;
  assign sel_price  = price_of(item_sel, 8'(PRICE_1), 8'(PRICE_2), 8'(PRICE_3));
  assign item_price = price_of(item_q, 8'(PRICE_1), 8'(PRICE_2), 8'(PRICE_3));
  // Cannot underflow: entry to DISPENSE required credit >= price and
  // credit is frozen while dispensing.
  assign remainder  = credit_q - CREDIT_W'(item_price);

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    disp_d     = disp_q;
    item_d     = item_q;
    reject_d   = 1'b0;
    short_d    = 1'b0;
    take_coins = 1'b0;
    load       = 1'b0;
    load_val   = credit_q;
    case (state_q)
      ST_IDLE: begin
        credit_d = '0;
        if (coin_val != 8'd0) begin
          if (coin_val <= MAX_C) begin
            credit_d = CREDIT_W'(coin_val);
            state_d  = ST_COLLECT;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (cancel) begin
          load     = 1'b1;
          load_val = credit_q;
          state_d  = ST_CHANGE;
          reject_d = (coin_val != 8'd0);
        end else begin
          take_coins = 1'b1;
          if (select_valid && (item_sel != ITEM_NONE)) begin
            // Unsigned compare at credit width.
            if (credit_q >= CREDIT_W'(sel_price)) begin
              state_d    = ST_DISPENSE;
              disp_d     = 1'b1;
              item_d     = item_sel;
              reject_d   = (coin_val != 8'd0);
              take_coins = 1'b0;
            end else begin
              short_d = 1'b1;
            end
          end
          if (take_coins && (coin_val != 8'd0)) begin
            if (coin_sum > MAX_C) begin
              reject_d = 1'b1;
            end else begin
              credit_d = CREDIT_W'(coin_sum);
            end
          end
        end
      end
      ST_DISPENSE: begin
        reject_d = (coin_val != 8'd0);
        if (dispense_ready) begin
          credit_d = remainder;
          disp_d   = 1'b0;
          item_d   = ITEM_NONE;
          if (remainder != '0) begin
            load     = 1'b1;
            load_val = remainder;
            state_d  = ST_CHANGE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_CHANGE: begin
        reject_d = (coin_val != 8'd0);
        // Credit tracks the hopper: it drops as each nickel leaves.
        if (seq_nickel) begin
          credit_d = credit_q - CREDIT_W'(NICKEL_C);
        end
        if (seq_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      disp_q   <= 1'b0;
      item_q   <= ITEM_NONE;
      reject_q <= 1'b0;
      short_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      disp_q   <= disp_d;
      item_q   <= item_d;
      reject_q <= reject_d;
      short_q  <= short_d;
      busy_q   <= busy_d;
    end
  end

  change_sequencer #(
    .CREDIT_W(CREDIT_W)
  ) u_change (
    .clock       (clock),
    .reset       (reset),
    .load_i      (load),
    .credit_i    (load_val),
    .nickel_out_o(seq_nickel),
    .done_o      (seq_done)
  );

  assign dispense      = disp_q;
  assign dispense_item = item_q;
  assign nickel_out    = seq_nickel;
  assign coin_reject   = reject_q;
  assign sel_short     = short_q;
  assign credit        = credit_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: a directed vector table, a hand-written
// reset-during-refund sequence, then random stimulus compared against a
// transaction-level reference model (refunds modelled as a queue of
// expected nickel_out values).
module tb_vend_controller;

  localparam int MAX_CREDIT = 35;

  logic       clock;
  logic       reset;
  logic       nickel_in;
  logic       dime_in;
  logic [1:0] item_sel;
  logic       select_valid;
  logic       cancel;
  logic       dispense_ready;
  logic       dispense;
  logic [1:0] dispense_item;
  logic       nickel_out;
  logic       coin_reject;
  logic       sel_short;
  logic [5:0] credit;
  logic       busy;

  vend_controller dut (
    .clock         (clock),
    .reset         (reset),
    .nickel_in     (nickel_in),
    .dime_in       (dime_in),
    .item_sel      (item_sel),
    .select_valid  (select_valid),
    .cancel        (cancel),
    .dispense_ready(dispense_ready),
    .dispense      (dispense),
    .dispense_item (dispense_item),
    .nickel_out    (nickel_out),
    .coin_reject   (coin_reject),
    .sel_short     (sel_short),
    .credit        (credit),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       n;
    logic       d;
    logic       sv;
    logic [1:0] item;
    logic       c;
    logic       rdy;
    int         e_credit;
    logic       e_disp;
    logic [1:0] e_item;
    logic       e_nout;
    logic       e_rej;
    logic       e_short;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: mode 0 idle, 1 collecting, 2 dispensing, 3 refunding.
  int   m_mode;
  int   m_credit;
  int   m_item;
  bit   m_q[$];
  bit   m_nout, m_rej, m_short;
  int   price_tab[4];

  task automatic add(input logic rst, input logic n, input logic d, input logic sv,
                     input logic [1:0] item, input logic c, input logic rdy,
                     input int ec, input logic edisp, input logic [1:0] eitem,
                     input logic enout, input logic erej, input logic eshort,
                     input logic ebusy);
    vec_t v;
    v.rst = rst; v.n = n; v.d = d; v.sv = sv; v.item = item; v.c = c; v.rdy = rdy;
    v.e_credit = ec; v.e_disp = edisp; v.e_item = eitem; v.e_nout = enout;
    v.e_rej = erej; v.e_short = eshort; v.e_busy = ebusy;
    vecs.push_back(v);
  endtask

  task automatic model_reset();
    m_mode = 0; m_credit = 0; m_item = 0; m_q.delete();
    m_nout = 0; m_rej = 0; m_short = 0;
  endtask

  task automatic start_refund();
    m_q.delete();
    for (int k = 0; k < 2 * (m_credit / 5) - 1; k++) m_q.push_back(k % 2 == 0);
    m_mode = 3;
  endtask

  task automatic model_step();
    int cv;
    bit coins_ok;
    bit popped;
    cv = (nickel_in ? 5 : 0) + (dime_in ? 10 : 0);
    m_rej = 0;
    m_short = 0;
    coins_ok = 1;
    case (m_mode)
      0: begin
        if (cv > 0) begin
          if (cv <= MAX_CREDIT) begin m_credit = cv; m_mode = 1; end
          else m_rej = 1;
        end
      end
      1: begin
        if (cancel) begin
          m_rej = (cv > 0);
          start_refund();
        end else begin
          if (select_valid && item_sel != 2'd0) begin
            if (m_credit >= price_tab[item_sel]) begin
              m_mode = 2; m_item = int'(item_sel); m_rej = (cv > 0); coins_ok = 0;
            end else begin
              m_short = 1;
            end
          end
          if (coins_ok && cv > 0) begin
            if (m_credit + cv > MAX_CREDIT) m_rej = 1;
            else m_credit = m_credit + cv;
          end
        end
      end
      2: begin
        m_rej = (cv > 0);
        if (dispense_ready) begin
          m_credit = m_credit - price_tab[m_item];
          if (m_credit > 0) start_refund();
          else m_mode = 0;
        end
      end
      default: begin
        m_rej = (cv > 0);
        popped = m_q.pop_front();
        if (popped) m_credit = m_credit - 5;
        if (m_q.size() == 0) m_mode = 0;
      end
    endcase
    m_nout = (m_mode == 3 && m_q.size() > 0) ? m_q[0] : 1'b0;
  endtask

  task automatic check_outs(input string tag, input int idx, input int ec,
                            input logic edisp, input logic [1:0] eitem,
                            input logic enout, input logic erej,
                            input logic eshort, input logic ebusy);
    bit bad;
    checks++;
    bad = (int'(credit) != ec) || (dispense !== edisp) || (nickel_out !== enout) ||
          (coin_reject !== erej) || (sel_short !== eshort) || (busy !== ebusy) ||
          (edisp && dispense_item !== eitem);
    if (bad) begin
      errors++;
      $display("FAIL %s #%0d: got credit=%0d disp=%0b item=%0d nout=%0b rej=%0b short=%0b busy=%0b; want credit=%0d disp=%0b item=%0d nout=%0b rej=%0b short=%0b busy=%0b",
               tag, idx, credit, dispense, dispense_item, nickel_out, coin_reject,
               sel_short, busy, ec, edisp, eitem, enout, erej, eshort, ebusy);
    end else begin
      $display("ok   %s #%0d: credit=%0d disp=%0b item=%0d nout=%0b rej=%0b short=%0b busy=%0b",
               tag, idx, credit, dispense, dispense_item, nickel_out, coin_reject,
               sel_short, busy);
    end
  endtask

  // One clock of stimulus; the model advances alongside the DUT.
  task automatic drive_cycle(input logic rst, input logic n, input logic d,
                             input logic sv, input logic [1:0] item,
                             input logic c, input logic rdy);
    reset = rst; nickel_in = n; dime_in = d; select_valid = sv;
    item_sel = item; cancel = c; dispense_ready = rdy;
    @(posedge clock);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic apply_vec(input vec_t v, input string tag, input int idx);
    drive_cycle(v.rst, v.n, v.d, v.sv, v.item, v.c, v.rdy);
    check_outs(tag, idx, v.e_credit, v.e_disp, v.e_item, v.e_nout, v.e_rej,
               v.e_short, v.e_busy);
  endtask

  vec_t hv;

  initial begin
    price_tab[0] = 0; price_tab[1] = 15; price_tab[2] = 20; price_tab[3] = 25;
    model_reset();
    reset = 1; nickel_in = 0; dime_in = 0; item_sel = 0;
    select_valid = 0; cancel = 0; dispense_ready = 0;
    repeat (2) @(posedge clock);
    #1;
    check_outs("reset", 0, 0, 0, 2'd0, 0, 0, 0, 0);
    if (dispense_item !== 2'd0) begin
      errors++;
      $display("FAIL reset_item: got %0d want 0", dispense_item);
    end
    checks++;

    //   rst n d sv it c r | credit disp item nout rej short busy
    // exact payment
    add(0,0,1,0,0,0,0, 10,0,0,0,0,0,0);
    add(0,0,1,0,0,0,0, 20,0,0,0,0,0,0);
    add(0,0,0,1,2,0,0, 20,1,2,0,0,0,1);
    add(0,0,0,0,0,0,0, 20,1,2,0,0,0,1);
    add(0,0,0,0,0,0,1,  0,0,0,0,0,0,0);
    // change after dispense
    add(0,0,1,0,0,0,0, 10,0,0,0,0,0,0);
    add(0,0,1,0,0,0,0, 20,0,0,0,0,0,0);
    add(0,0,0,1,1,0,0, 20,1,1,0,0,0,1);
    add(0,0,0,0,0,0,1,  5,0,0,1,0,0,1);
    add(0,0,0,0,0,0,0,  0,0,0,0,0,0,0);
    // cancel refund of 25
    add(0,1,1,0,0,0,0, 15,0,0,0,0,0,0);
    add(0,0,1,0,0,0,0, 25,0,0,0,0,0,0);
    add(0,0,0,0,0,1,0, 25,0,0,1,0,0,1);
    add(0,0,0,0,0,0,0, 20,0,0,0,0,0,1);
    add(0,0,0,0,0,0,0, 20,0,0,1,0,0,1);
    add(0,0,0,0,0,0,0, 15,0,0,0,0,0,1);
    add(0,0,0,0,0,0,0, 15,0,0,1,0,0,1);
    add(0,0,0,0,0,0,0, 10,0,0,0,0,0,1);
    add(0,0,0,0,0,0,0, 10,0,0,1,0,0,1);
    add(0,0,0,0,0,0,0,  5,0,0,0,0,0,1);
    add(0,0,0,0,0,0,0,  5,0,0,1,0,0,1);
    add(0,0,0,0,0,0,0,  0,0,0,0,0,0,0);
    // short credit, then overflow at 35
    add(0,0,1,0,0,0,0, 10,0,0,0,0,0,0);
    add(0,0,0,1,3,0,0, 10,0,0,0,0,1,0);
    add(0,0,1,0,0,0,0, 20,0,0,0,0,0,0);
    add(0,0,1,0,0,0,0, 30,0,0,0,0,0,0);
    add(0,0,1,0,0,0,0, 30,0,0,0,1,0,0);
    add(0,1,0,0,0,0,0, 35,0,0,0,0,0,0);
    // coins during dispense, then 10 cents change
    add(0,0,0,1,3,0,0, 35,1,3,0,0,0,1);
    add(0,0,1,0,0,0,0, 35,1,3,0,1,0,1);
    add(0,1,0,1,1,0,0, 35,1,3,0,1,0,1);
    add(0,0,0,0,0,0,1, 10,0,0,1,0,0,1);
    add(0,0,0,0,0,0,0,  5,0,0,0,0,0,1);
    add(0,0,0,0,0,0,0,  5,0,0,1,0,0,1);
    add(0,0,0,0,0,0,0,  0,0,0,0,0,0,0);
    // cancel with a same-cycle coin
    add(0,1,0,0,0,0,0,  5,0,0,0,0,0,0);
    add(0,0,1,0,0,1,0,  5,0,0,1,1,0,1);
    add(0,0,0,0,0,0,0,  0,0,0,0,0,0,0);
    // item 0 ignored, short with coin, exact buy with rejected coin
    add(0,0,1,1,0,0,0, 10,0,0,0,0,0,0);
    add(0,1,0,1,3,0,0, 15,0,0,0,0,1,0);
    add(0,0,1,1,1,0,0, 15,1,1,0,1,0,1);
    add(0,0,0,0,0,0,1,  0,0,0,0,0,0,0);
    // select and cancel ignored in IDLE
    add(0,0,0,1,1,1,0,  0,0,0,0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], "vec", i);

    // Reset in the middle of a 4-nickel refund, after two pulses.
    drive_cycle(0,0,1,0,0,0,0); check_outs("rstchg", 0, 10,0,0,0,0,0,0);
    drive_cycle(0,0,1,0,0,0,0); check_outs("rstchg", 1, 20,0,0,0,0,0,0);
    drive_cycle(0,0,0,0,0,1,0); check_outs("rstchg", 2, 20,0,0,1,0,0,1);
    drive_cycle(0,0,0,0,0,0,0); check_outs("rstchg", 3, 15,0,0,0,0,0,1);
    drive_cycle(0,0,0,0,0,0,0); check_outs("rstchg", 4, 15,0,0,1,0,0,1);
    drive_cycle(0,0,0,0,0,0,0); check_outs("rstchg", 5, 10,0,0,0,0,0,1);
    hv = '{rst:1, n:0, d:0, sv:0, item:0, c:0, rdy:0, e_credit:0, e_disp:0,
           e_item:0, e_nout:0, e_rej:0, e_short:0, e_busy:0};
    apply_vec(hv, "rstchg", 6);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0,0,0,0,0,0,0);
      check_outs("rstchg_after", i, 0,0,0,0,0,0,0);
    end

    // Random stimulus against the reference model.
    for (int i = 0; i < 3000; i++) begin
      drive_cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) == 0,
                  2'($urandom_range(0, 3)),
                  $urandom_range(0, 24) == 0,
                  $urandom_range(0, 2) == 0);
      check_outs("rand", i, m_credit, m_mode == 2, 2'(m_item), m_nout, m_rej,
                 m_short, (m_mode == 2) || (m_mode == 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
Top-level vending sequencer that owns coin credit for a three-item machine with prices 15/20/25 cents. It accepts nickel/dime pulses and a one-cycle item-selection request. It then drives a dispense handshake to the dispense mechanism and returns change as paced nickel_out pulses. It is the single scheduler that shares the coin path and change hopper between the three item slots.

Parameters:
PRICE_1, 15, price of item 1 in cents (multiple of 5)
PRICE_2, 20, price of item 2 in cents
PRICE_3, 25, price of item 3 in cents
MAX_CREDIT, 35, highest credit accepted in cents (multiple of 5, <= 63)
CREDIT_W, 6, width of credit register

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
nickel_in  in  1  one-cycle pulse, 5 cents inserted
dime_in  in  1  one-cycle pulse, 10 cents inserted
item_sel  in  2  item code: 0 none, 1..3 item
select_valid  in  1  one-cycle request to buy item_sel
cancel  in  1  one-cycle request to refund all credit
dispense_ready  in  1  mechanism accepted the dispense
dispense  out  1  held high until dispense_ready is sampled
dispense_item  out  2  latched item code, valid while dispense=1
nickel_out  out  1  one-cycle pulse, one nickel returned
coin_reject  out  1  one-cycle pulse, this cycle's coins physically returned
sel_short  out  1  one-cycle pulse, selection refused for insufficient credit
credit  out  CREDIT_W  current credit in cents
busy  out  1  high in DISPENSE or CHANGE

Behaviour:
- All outputs are registered. Reset forces state IDLE, credit 0 and every output 0, regardless of state (including mid-DISPENSE or mid-CHANGE). Credit held at reset is discarded.
- Coin value per cycle: nickel_in*5 + dime_in*10. Both inputs high in the same cycle gives +15.
- A coin accepted in cycle n is reflected on credit in cycle n+1.
- States: IDLE, COLLECT, DISPENSE, CHANGE.
- IDLE: credit=0.
  - Coin value > 0 and <= MAX_CREDIT: credit <= value, go to COLLECT.
  - select_valid and cancel are ignored in IDLE.
- COLLECT: priority is cancel > select_valid > coins.
  - cancel: go to CHANGE with the current credit. Any coins in the same cycle raise coin_reject.
  - select_valid with item_sel=0: ignored; coins are processed normally.
  - select_valid with item_sel!=0 and credit >= price: latch item, go to DISPENSE. Same-cycle coins raise coin_reject.
  - select_valid with item_sel!=0 and credit < price: pulse sel_short, stay in COLLECT. Same-cycle coins are processed normally.
  - Coins otherwise: if credit + value > MAX_CREDIT, pulse coin_reject and leave credit unchanged (the whole cycle's coins are rejected). Else credit += value.
- DISPENSE:
  - dispense=1 and dispense_item=latched item from the first DISPENSE cycle.
  - On the cycle dispense_ready is sampled high: credit <= credit - price and dispense drops next cycle. Next state is CHANGE if the remainder is > 0, else IDLE.
  - No timeout: the block waits indefinitely for dispense_ready.
  - cancel and select_valid are ignored. Any coin raises coin_reject.
- CHANGE:
  - nickel_out pulses on the first CHANGE cycle and then every second cycle.
  - Each pulse decrements credit by 5 in the same cycle.
  - After the pulse that brings credit to 0, go to IDLE next cycle. A refund of N nickels therefore spans 2N-1 cycles of pulses.
  - Coins raise coin_reject; cancel and select_valid are ignored.
- Credit never exceeds MAX_CREDIT and never underflows; the price comparison is unsigned and CREDIT_W wide.
- busy = (state==DISPENSE || state==CHANGE).

Decomposition:
- Package vend_pkg holds:
  - state enum {IDLE, COLLECT, DISPENSE, CHANGE}
  - coin constants NICKEL_C=5, DIME_C=10
  - item code constants ITEM_NONE, ITEM_1, ITEM_2, ITEM_3
  - a price-lookup function taking item code and the three prices
- One sub-module, change_sequencer. It takes a load pulse and a credit value, and emits paced nickel_out pulses plus a done flag. It is reused for both the cancel refund and post-dispense change.

Test Plan:
- Exact payment: dime, dime (credit 20), select item 2 -> dispense=1, dispense_item=2. On dispense_ready: credit 0, no nickel_out, back to IDLE, busy=0.
- Change: dime, dime (20), select item 1 -> dispense. After ready: one nickel_out pulse, credit 5 -> 0, then IDLE.
- Cancel refund: nickel+dime same cycle (15), dime (25), cancel -> 5 nickel_out pulses on alternate cycles, credit 25, 20, 15, 10, 5, 0, then IDLE.
- Overflow (MAX 35): credit 30 + dime -> coin_reject pulse, credit stays 30. Then nickel -> credit 35.
- Short credit: credit 10, select item 3 -> sel_short pulse, state stays COLLECT, credit 10. Coin during DISPENSE -> coin_reject, credit unchanged.
- Reset mid-CHANGE after 2 of 4 nickels -> next cycle: state IDLE, credit 0, nickel_out/dispense/busy all 0, no further pulses.
